// File: rtl/scratchpad_port_arbiter.sv
// scratchpad_port_arbiter
//   Shares one scratchpad SRAM (one write port, one registered read port)
//   between two requesters. Conflicts are resolved round-robin. A requester
//   may lock the grant for a bounded burst of up to LOCK_MAX extra grants.
//   Reads are tagged in a READ_LATENCY-deep pipeline, so each returning word
//   is flagged to the requester that issued it.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   rN_req/we/lock/addr/wdata   request from requester N (held until gnt)
//   rN_gnt                      request accepted this cycle
//   rN_rvalid, rN_rdata         read return for requester N
//   sram_write_*                SRAM write port
//   sram_read_address           SRAM read address (holds when idle)
//   sram_read_data              SRAM read data
module scratchpad_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_MAX     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            lk;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    lock_state_e lock_state, lock_state_n;
    logic        lock_owner, lock_owner_n;
    logic [7:0]  lock_cnt, lock_cnt_n;
    logic        prio, prio_n;

    logic win;
    logic locked_win;
    logic any_gnt;
    logic wr_gnt;
    logic rd_gnt;

    logic [ADDR_WIDTH-1:0] wa_q;
    logic [ADDR_WIDTH-1:0] ra_q;
    logic [DATA_WIDTH-1:0] wd_q;

    logic [READ_LATENCY-1:0] trk_v;
    logic [READ_LATENCY-1:0] trk_id;

    assign req      = {r1_req, r0_req};
    assign we       = {r1_we, r0_we};
    assign lk       = {r1_lock, r0_lock};
    assign addr[0]  = r0_addr;
    assign addr[1]  = r1_addr;
    assign wdata[0] = r0_wdata;
    assign wdata[1] = r1_wdata;

    // Winner selection. The lock owner keeps the port while it requests,
    // unless it has used up its burst allowance and the other side waits.
    always_comb begin
        win        = 1'b0;
        locked_win = 1'b0;
        if (lock_state == LOCK_HELD && req[lock_owner] &&
            !(lock_cnt >= LOCK_LIMIT && req[~lock_owner])) begin
            win        = lock_owner;
            locked_win = 1'b1;
        end else if (&req) begin
            win = prio;
        end else begin
            win = req[1];
        end
    end

    assign any_gnt = (|req) && !reset;
    assign r0_gnt  = any_gnt && !win;
    assign r1_gnt  = any_gnt && win;
    assign wr_gnt  = any_gnt && we[win];
    assign rd_gnt  = any_gnt && !we[win];

    // Lock bookkeeping: a fresh lock starts counting at zero; each grant taken
    // through the lock increments the count (saturating at 8 bits).
    always_comb begin
        prio_n       = prio;
        lock_state_n = LOCK_FREE;
        lock_owner_n = lock_owner;
        lock_cnt_n   = '0;
        if (any_gnt) begin
            prio_n = ~win;
            if (lk[win]) begin
                lock_state_n = LOCK_HELD;
                lock_owner_n = win;
                if (locked_win) begin
                    lock_cnt_n = (lock_cnt == '1) ? lock_cnt : lock_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= LOCK_FREE;
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
            prio       <= 1'b0;
        end else begin
            lock_state <= lock_state_n;
            lock_owner <= lock_owner_n;
            lock_cnt   <= lock_cnt_n;
            prio       <= prio_n;
        end
    end

    // SRAM drive; the shadows keep the address/data buses quiet when idle.
    assign sram_write_enable  = wr_gnt;
    assign sram_write_address = wr_gnt ? addr[win]  : wa_q;
    assign sram_write_data    = wr_gnt ? wdata[win] : wd_q;
    assign sram_read_address  = rd_gnt ? addr[win]  : ra_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wa_q <= '0;
            wd_q <= '0;
            ra_q <= '0;
        end else begin
            wa_q <= sram_write_address;
            wd_q <= sram_write_data;
            ra_q <= sram_read_address;
        end
    end

    // Read tag pipeline. Bit 0 is the head; written as a shift-and-insert so
    // the same expression also covers READ_LATENCY == 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_v  <= '0;
            trk_id <= '0;
        end else begin
            trk_v  <= (trk_v << 1)  | READ_LATENCY'(rd_gnt);
            trk_id <= (trk_id << 1) | READ_LATENCY'(win);
        end
    end

    assign r0_rvalid = trk_v[READ_LATENCY-1] && !trk_id[READ_LATENCY-1];
    assign r1_rvalid = trk_v[READ_LATENCY-1] && trk_id[READ_LATENCY-1];
    assign r0_rdata  = sram_read_data;
    assign r1_rdata  = sram_read_data;

endmodule

// File: doc/scratchpad_port_arbiter.md
# scratchpad_port_arbiter

- Shares the single-port-per-direction scratchpad SRAM (12-bit address, 16-bit data, one write port, one registered read port) between two on-chip requesters.
- Typical requesters: the convolution engine (requester 0) and the pooling/output engine (requester 1) inside MyDesign.
- Provides round-robin arbitration with optional bounded locking for bursts.
- Tracks outstanding reads so returned data is tagged to the requester that issued the read.

## Interface
Parameters:
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- READ_LATENCY, 1, cycles from read address to valid sram_read_data; legal range 1..4
- LOCK_MAX, 16, maximum consecutive locked grants to one requester; legal range 1..255

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rN_req  in  1  request from requester N (N=0,1)
- rN_we  in  1  1=write, 0=read
- rN_lock  in  1  keep grant next cycle if still requesting
- rN_addr  in  ADDR_WIDTH  access address
- rN_wdata  in  DATA_WIDTH  write data
- rN_gnt  out  1  access accepted this cycle
- rN_rvalid  out  1  rN_rdata holds data for an earlier read by N
- rN_rdata  out  DATA_WIDTH  read data, driven from sram_read_data
- sram_write_enable  out  1  to SRAM write_enable
- sram_write_address  out  ADDR_WIDTH  to SRAM write_address
- sram_write_data  out  DATA_WIDTH  to SRAM write_data
- sram_read_address  out  ADDR_WIDTH  to SRAM read_address
- sram_read_data  in  DATA_WIDTH  from SRAM read_data

## Operation
- **Grant logic**
  - Grant is combinational from the current-cycle requests and registered state.
  - At most one of r0_gnt/r1_gnt is high in any cycle.
  - A request is accepted in the cycle its gnt is high.
  - The requester holds req/we/addr/wdata stable until gnt.
- **Round-robin priority**
  - A registered pointer prio (0 or 1) names the requester that wins a conflict.
  - After a grant to N, prio becomes 1-N.
  - A single requester is always granted, whatever prio is.
- **Lock**
  - lock_owner and lock_cnt (8 bits) are registered.
  - If the granted requester had rN_lock=1, it owns the lock for the next cycle.
  - While a lock is owned and the owner requests, the owner is granted regardless of prio, and lock_cnt increments.
  - When lock_cnt reaches LOCK_MAX and the other requester is requesting, the lock is dropped and the other requester is granted.
  - The lock is also dropped when the owner deasserts req or lock; lock_cnt then clears.
- **SRAM drive**
  - Granted write: sram_write_enable=1, with sram_write_address/sram_write_data taken from the granted requester.
  - Granted read: sram_read_address = granted rN_addr.
  - When idle, sram_read_address holds its last value (registered shadow); sram_write_enable=0.
- **Read tracking**
  - A shift register of READ_LATENCY entries holds {valid, id}.
  - A granted read enters {1, N} at the head.
  - At the tail, valid with id N raises rN_rvalid for one cycle.
  - Both rN_rdata outputs equal sram_read_data at all times; only rvalid is steered.
  - Back-to-back reads from either requester are supported every cycle.
- **Simultaneous events**
  - A read grant and an rvalid for an older read may occur in the same cycle. Both are honoured.
  - Write-then-read to the same address in consecutive cycles returns the new data, as the SRAM writes on the edge before the read is registered.

## Timing
- Reset values:
  - gnt, rvalid, and sram_write_enable are 0.
  - sram_read_address, sram_write_address, and sram_write_data are 0.
  - prio=0, so r0 wins the first conflict.
  - The lock is cleared and lock_cnt=0.
  - All tracking entries are invalid.
- While reset is high, all grants are forced to 0.
- Grant latency: 0 cycles when uncontended; at most 1 cycle of wait when contended and unlocked; at most LOCK_MAX cycles when locked.
- Read data latency: rN_rvalid rises exactly READ_LATENCY cycles after the accepting gnt edge.
- Writes take effect at the grant edge and produce no rvalid.
- Reset asserted mid-operation discards outstanding reads; no rvalid is issued for them after reset release.

## Test plan
- **Single requester, uncontended.** r0 writes 0xBEEF to address 0x010, then reads 0x010 the next cycle. Required: r0_gnt on both cycles; r0_rvalid one cycle after the read grant with r0_rdata=0xBEEF; r1_rvalid stays 0.
- **Contention, round-robin.** Both requesters read continuously (r0 from 0x000 upward, r1 from 0x800 upward) for 8 cycles. Required: grants alternate r0,r1,r0,…; each rvalid pulses to the correct id with matching data.
- **Lock bound.** r0 reads with lock=1 for 40 cycles while r1 requests continuously. Required: r0 gets 1+LOCK_MAX (17) consecutive grants, then r1 is granted once, then r0 resumes.
- **READ_LATENCY=3 pipelining.** With READ_LATENCY=3, reads are issued r0, r1, r0 on consecutive cycles. Required: rvalid appears on r0, r1, r0 on cycles 3, 4, 5 after the first grant.
- **Reset mid-read.** Reset is asserted one cycle after a read grant with READ_LATENCY=2. Required: no rvalid after reset release; the first post-reset conflict is granted to r0.
